loba3_seq: RTL and testbench

Sequential, resource-shared LOBA approximate multiplier controller for the rtl16 family. It accepts one N-bit operand pair through a valid/ready handshake and splits each operand into high and low W-bit leading-one windows. It then schedules the four window partial products through a single W×W multiplier, one term per cycle, skipping terms that are zero. It is the area-reduced, multi-cycle counterpart of the combinational LOBA3 multipliers and sits between an operand source and a result consumer.

---
 rtl/loba3_seq.sv | 150 +++++++++++++++
 tb/tb_loba3_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/loba3_seq.sv
// Sequential LOBA approximate multiplier: splits each operand into two leading-one
// windows and accumulates the nonzero window products through one shared WxW multiplier.
module loba3_seq #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P,
  output logic [2:0]     terms,
  output logic           busy
);

  localparam int unsigned SW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, SPLIT, MAC, DONE} state_t;

  state_t state, state_next;

  logic [N-1:0]   a_reg, b_reg;
  logic [W-1:0]   ah_r, al_r, bh_r, bl_r;
  logic [SW-1:0]  sah_r, sal_r, sbh_r, sbl_r;
  logic [3:0]     pend;
  logic [2*N-1:0] acc;
  logic [2:0]     term_cnt;

  // Returns {shift, mantissa} of the W-bit window starting at the leading one of x.
  function automatic logic [SW+W-1:0] win(input logic [N-1:0] x);
    int unsigned k;
    logic [SW-1:0] s;
    k = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (x[i]) k = i;
    end
    s = (k >= W - 1) ? SW'(k - (W - 1)) : '0;
    return {s, W'(x >> s)};
  endfunction

  logic [W-1:0]  ah_c, al_c, bh_c, bl_c;
  logic [SW-1:0] sah_c, sal_c, sbh_c, sbl_c;
  logic [N-1:0]  ra_c, rb_c;
  logic [3:0]    mask_c;

  always_comb begin
    {sah_c, ah_c} = win(a_reg);
    ra_c          = a_reg - (N'(ah_c) << sah_c);
    {sal_c, al_c} = win(ra_c);
    {sbh_c, bh_c} = win(b_reg);
    rb_c          = b_reg - (N'(bh_c) << sbh_c);
    {sbl_c, bl_c} = win(rb_c);
    mask_c = {(al_c != '0) && (bl_c != '0), (al_c != '0) && (bh_c != '0),
              (ah_c != '0) && (bl_c != '0), (ah_c != '0) && (bh_c != '0)};
  end

  // Term index bit 1 picks the A low window, bit 0 the B low window.
  logic [1:0]     idx;
  logic [3:0]     pend_next;
  logic [W-1:0]   ma, mb;
  logic [SW:0]    sh;
  logic [2*W-1:0] prod;
  logic [2*N-1:0] term;

  always_comb begin
    idx = 2'd3;
    if (pend[0])      idx = 2'd0;
    else if (pend[1]) idx = 2'd1;
    else if (pend[2]) idx = 2'd2;
    pend_next = pend & ~(4'b0001 << idx);
    ma   = idx[1] ? al_r : ah_r;
    mb   = idx[0] ? bl_r : bh_r;
    sh   = (idx[1] ? {1'b0, sal_r} : {1'b0, sah_r}) + (idx[0] ? {1'b0, sbl_r} : {1'b0, sbh_r});
    prod = (2*W)'(ma) * (2*W)'(mb);
    term = (2*N)'(prod) << sh;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SPLIT;
      SPLIT:   state_next = (mask_c == '0) ? DONE : MAC;
      MAC:     if (pend_next == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      ah_r     <= '0;
      al_r     <= '0;
      bh_r     <= '0;
      bl_r     <= '0;
      sah_r    <= '0;
      sal_r    <= '0;
      sbh_r    <= '0;
      sbl_r    <= '0;
      pend     <= '0;
      acc      <= '0;
      term_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B;
          end
        end
        SPLIT: begin
          ah_r     <= ah_c;
          al_r     <= al_c;
          bh_r     <= bh_c;
          bl_r     <= bl_c;
          sah_r    <= sah_c;
          sal_r    <= sal_c;
          sbh_r    <= sbh_c;
          sbl_r    <= sbl_c;
          pend     <= mask_c;
          acc      <= '0;
          term_cnt <= '0;
        end
        MAC: begin
          acc      <= acc + term;
          term_cnt <= term_cnt + 3'd1;
          pend     <= pend_next;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign P         = acc;
  assign terms     = term_cnt;

endmodule

// File: tb/tb_loba3_seq.sv
// Self-checking bench for loba3_seq: directed spec cases, backpressure, mid-run reset
// and randomized operands against an arithmetic model of the LOBA window rules.
module tb_loba3_seq;

  localparam int unsigned N = 16;
  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A, B;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] P;
  logic [2:0]     terms;
  logic           busy;

  int total = 0;
  int bad   = 0;

  loba3_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .terms(terms), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void msplit(input longint unsigned x, output longint unsigned m,
                                 output longint unsigned s);
    longint unsigned k = 0;
    for (int i = 0; i < N; i++) if (((x >> i) & 1) == 1) k = i;
    s = (k >= W - 1) ? k - (W - 1) : 0;
    m = (x >> s) % (64'd1 << W);
  endfunction

  function automatic void model(input longint unsigned a, input longint unsigned b,
                                output longint unsigned p, output int unsigned n);
    longint unsigned ma[2], sa[2], mb[2], sb[2];
    msplit(a, ma[0], sa[0]);
    msplit(a - (ma[0] << sa[0]), ma[1], sa[1]);
    msplit(b, mb[0], sb[0]);
    msplit(b - (mb[0] << sb[0]), mb[1], sb[1]);
    p = 0;
    n = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (ma[i] != 0 && mb[j] != 0) begin
          p += (ma[i] * mb[j]) << (sa[i] + sb[j]);
          n++;
        end
  endfunction

  // Drives one transaction and reports what the DUT returned; callers do the checking.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int unsigned hold,
                       output logic [2*N-1:0] gp, output logic [2:0] gt,
                       output int unsigned lat, output bit steady, output bit tmo);
    int unsigned guard;
    tmo = 0; steady = 1; lat = 0; gp = '0; gt = '0;
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tmo = 1; in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; A = N'($urandom); B = N'($urandom);
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      out_ready = 1'($urandom_range(0, 1));
      lat++;
      if (lat > 20) begin
        tmo = 1; out_ready = 1'b0;
        return;
      end
    end
    gp = P; gt = terms;
    out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || P !== gp || terms !== gt || in_ready) steady = 0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || P !== '0 || terms !== 3'd0) begin
      bad++;
      $display("FAIL reset: got in_ready=%b out_valid=%b busy=%b P=%0d terms=%0d, want 1 0 0 0 0",
               in_ready, out_valid, busy, P, terms);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [N-1:0]   da[4] = '{16'h0000, 16'd15, 16'hFFFF, 16'hFFFF};
    logic [N-1:0]   db[4] = '{16'h1234, 16'd15, 16'h0001, 16'hFFFF};
    logic [2*N-1:0] ep[4] = '{32'd0, 32'd225, 32'd65280, 32'd4261478400};
    logic [2:0]     et[4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    int unsigned    el[4] = '{2, 3, 4, 6};
    logic [2*N-1:0] gp;
    logic [2:0]     gt;
    int unsigned    lat;
    bit             steady, tmo;
    for (int i = 0; i < 4; i++) begin
      do_op(da[i], db[i], 0, gp, gt, lat, steady, tmo);
      total++;
      if (tmo || gp !== ep[i] || gt !== et[i] || lat != el[i]) begin
        bad++;
        $display("FAIL directed[%0d]: got P=%0d terms=%0d lat=%0d tmo=%0b, want P=%0d terms=%0d lat=%0d",
                 i, gp, gt, lat, tmo, ep[i], et[i], el[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int unsigned guard;
    int unsigned lat;
    @(negedge clk);
    in_valid = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 20);
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL bp_valid: got out_valid=0 after %0d cycles, want 1", guard);
    end
    in_valid = 1'b1; A = 16'd15; B = 16'd15;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || P !== 32'd4261478400 || terms !== 3'd4 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b P=%0d terms=%0d in_ready=%b, want 1 4261478400 4 0",
                 c, out_valid, P, terms, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept: got busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 20) break;
      lat++;
    end
    total++;
    if (P !== 32'd225 || terms !== 3'd1 || lat != 3) begin
      bad++;
      $display("FAIL bp_next: got P=%0d terms=%0d lat=%0d, want 225 1 3", P, terms, lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [2*N-1:0] gp;
    logic [2:0]     gt;
    int unsigned    lat;
    bit             steady, tmo;
    @(negedge clk);
    in_valid = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    total++;
    if (terms !== 3'd1 || P !== 32'hE100_0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_partial: got terms=%0d P=%0h busy=%b, want 1 e1000000 1", terms, P, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (P !== '0 || terms !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got P=%0d terms=%0d out_valid=%b in_ready=%b busy=%b, want 0 0 0 1 0",
               P, terms, out_valid, in_ready, busy);
    end
    do_op(16'd15, 16'd15, 0, gp, gt, lat, steady, tmo);
    total++;
    if (tmo || gp !== 32'd225 || gt !== 3'd1 || lat != 3) begin
      bad++;
      $display("FAIL mid_after: got P=%0d terms=%0d lat=%0d tmo=%0b, want 225 1 3", gp, gt, lat, tmo);
    end
  endtask

  task automatic test_random;
    logic [N-1:0]    a, b;
    logic [2*N-1:0]  gp;
    logic [2:0]      gt;
    int unsigned     lat, n, hold;
    longint unsigned ep;
    bit              steady, tmo;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       a = N'($urandom);
        1:       a = N'($urandom) >> $urandom_range(0, N - 1);
        2:       a = '0;
        default: a = N'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 3))
        0:       b = N'($urandom);
        1:       b = N'($urandom) >> $urandom_range(0, N - 1);
        2:       b = N'($urandom_range(0, 255));
        default: b = '1;
      endcase
      hold = $urandom_range(0, 3);
      model(longint'(a), longint'(b), ep, n);
      do_op(a, b, hold, gp, gt, lat, steady, tmo);
      total++;
      if (tmo || !steady || gp !== (2*N)'(ep) || gt !== 3'(n) || lat != 2 + n) begin
        bad++;
        $display("FAIL rand[%0d] A=%h B=%h: got P=%0d terms=%0d lat=%0d steady=%0b tmo=%0b, want P=%0d terms=%0d lat=%0d",
                 i, a, b, gp, gt, lat, steady, tmo, ep, n, 2 + n);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
